// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshakes on both sides.
//   Single-cycle ops load the result registers at the accept edge (latency 1).
//   MUL runs a WIDTH-step shift-add sequence and produces a 2*WIDTH product.
//   With CARRY_SRC=1 an internal carry register feeds ADC, allowing chained adds.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake; A, B, opcode, car_in sampled at accept
//   out_valid/out_ready result handshake
//   y, y_hi           result (y_hi nonzero only for MUL)
//   car_out, borrow, zero, parity, invalid_op   result flags
module alu_pipe #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          CARRY_SRC = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       opcode,
    input  logic             car_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             car_out,
    output logic             borrow,
    output logic             zero,
    output logic             parity,
    output logic             invalid_op
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic { S_IDLE, S_MUL } state_e;

    typedef enum logic [3:0] {
        OP_ADD = 4'd1,  OP_ADC = 4'd2,  OP_SUB = 4'd3,  OP_INC = 4'd4,
        OP_DEC = 4'd5,  OP_AND = 4'd6,  OP_NOT = 4'd7,  OP_ROL = 4'd8,
        OP_ROR = 4'd9,  OP_MUL = 4'd10, OP_OR  = 4'd11, OP_XOR = 4'd12
    } op_e;

    state_e               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     y_q, y_d, y_hi_q, y_hi_d;
    logic                 car_q, car_d, borrow_q, borrow_d;
    logic                 zero_q, zero_d, parity_q, parity_d, inv_q, inv_d;
    logic                 carry_reg_q, carry_reg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH-1:0]     alu_y;
    logic                 alu_car, alu_borrow, alu_inv, cin;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic                 accept, drain;

    assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready) && !rst;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    // Single-cycle datapath
    always_comb begin
        alu_y      = '0;
        alu_car    = 1'b0;
        alu_borrow = 1'b0;
        alu_inv    = 1'b0;
        sum        = '0;
        cin        = CARRY_SRC ? carry_reg_q : car_in;
        case (opcode)
            OP_ADD: begin
                sum     = {1'b0, A} + {1'b0, B};
                alu_y   = sum[WIDTH-1:0];
                alu_car = sum[WIDTH];
            end
            OP_ADC: begin
                sum     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
                alu_y   = sum[WIDTH-1:0];
                alu_car = sum[WIDTH];
            end
            OP_SUB: begin
                alu_y      = A - B;
                alu_borrow = (A < B);
            end
            OP_INC: begin
                sum     = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
                alu_y   = sum[WIDTH-1:0];
                alu_car = sum[WIDTH];
            end
            OP_DEC: begin
                alu_y      = A - {{(WIDTH-1){1'b0}}, 1'b1};
                alu_borrow = (A == '0);
            end
            OP_AND:  alu_y = A & B;
            OP_NOT:  alu_y = ~A;
            OP_ROL:  alu_y = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_ROR:  alu_y = {A[0], A[WIDTH-1:1]};
            OP_MUL:  alu_y = '0;
            OP_OR:   alu_y = A | B;
            OP_XOR:  alu_y = A ^ B;
            default: alu_inv = 1'b1;
        endcase
    end

    // Shift-add step: multiplier sits in the low half of prod and is consumed
    // LSB first while partial sums accumulate into the high half.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        y_hi_d      = y_hi_q;
        car_d       = car_q;
        borrow_d    = borrow_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        inv_d       = inv_q;
        carry_reg_d = carry_reg_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;

        if (drain) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        mcand_d = A;
                        prod_d  = {{WIDTH{1'b0}}, B};
                        cnt_d   = CW'(WIDTH);
                        state_d = S_MUL;
                    end else begin
                        y_d         = alu_y;
                        y_hi_d      = '0;
                        car_d       = alu_car;
                        borrow_d    = alu_borrow;
                        zero_d      = (alu_y == '0);
                        parity_d    = ^alu_y;
                        inv_d       = alu_inv;
                        out_valid_d = 1'b1;
                        if (CARRY_SRC && (opcode == OP_ADD || opcode == OP_ADC ||
                                          opcode == OP_INC)) begin
                            carry_reg_d = alu_car;
                        end
                    end
                end
            end
            S_MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    y_d         = mul_next[WIDTH-1:0];
                    y_hi_d      = mul_next[2*WIDTH-1:WIDTH];
                    car_d       = 1'b0;
                    borrow_d    = 1'b0;
                    zero_d      = (mul_next == '0);
                    parity_d    = ^mul_next[WIDTH-1:0];
                    inv_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_hi_q      <= '0;
            car_q       <= 1'b0;
            borrow_q    <= 1'b0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            inv_q       <= 1'b0;
            carry_reg_q <= 1'b0;
            cnt_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            y_hi_q      <= y_hi_d;
            car_q       <= car_d;
            borrow_q    <= borrow_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            inv_q       <= inv_d;
            carry_reg_q <= carry_reg_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign y          = y_q;
    assign y_hi       = y_hi_q;
    assign car_out    = car_q;
    assign borrow     = borrow_q;
    assign zero       = zero_q;
    assign parity     = parity_q;
    assign invalid_op = inv_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: an 8-bit instance with car_in carry, an 8-bit
// instance with the internal carry register, and a 16-bit instance.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, car_in;
    logic [7:0]  A, B;
    logic [3:0]  opcode;

    logic        in_ready, out_valid, car_out, borrow, zero, parity, invalid_op;
    logic [7:0]  y, y_hi;
    logic        c_in_ready, c_out_valid, c_car, c_borrow, c_zero, c_parity, c_inv;
    logic [7:0]  c_y, c_y_hi;

    logic        v16, r16;
    logic [15:0] a16, b16;
    logic [3:0]  op16;
    logic        w_in_ready, w_valid, w_car, w_borrow, w_zero, w_parity, w_inv;
    logic [15:0] w_y, w_hi;

    int errors = 0;
    int checks = 0;
    int busy, seen, early;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .CARRY_SRC(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .car_in(car_in),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_hi(y_hi),
        .car_out(car_out), .borrow(borrow), .zero(zero), .parity(parity),
        .invalid_op(invalid_op)
    );

    alu_pipe #(.WIDTH(8), .CARRY_SRC(1'b1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
        .A(A), .B(B), .opcode(opcode), .car_in(car_in),
        .out_valid(c_out_valid), .out_ready(out_ready), .y(c_y), .y_hi(c_y_hi),
        .car_out(c_car), .borrow(c_borrow), .zero(c_zero), .parity(c_parity),
        .invalid_op(c_inv)
    );

    alu_pipe #(.WIDTH(16), .CARRY_SRC(1'b0)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(w_in_ready),
        .A(a16), .B(b16), .opcode(op16), .car_in(car_in),
        .out_valid(w_valid), .out_ready(r16), .y(w_y), .y_hi(w_hi),
        .car_out(w_car), .borrow(w_borrow), .zero(w_zero), .parity(w_parity),
        .invalid_op(w_inv)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        opcode   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; car_in = 1'b0;
        A = '0; B = '0; opcode = '0;
        v16 = 1'b0; r16 = 1'b1; a16 = '0; b16 = '0; op16 = '0;
        tick(); tick();

        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_y_hi", 32'(y_hi), 0);
        chk("rst_zero", 32'(zero), 0);
        chk("rst_car", 32'(car_out), 0);
        chk("rst_inv", 32'(invalid_op), 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 1);

        // ADD 200+100
        in_valid = 1'b1; opcode = 4'd1; A = 8'd200; B = 8'd100;
        tick();
        in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 1);
        chk("add_y", 32'(y), 44);
        chk("add_car", 32'(car_out), 1);
        chk("add_zero", 32'(zero), 0);
        chk("add_parity", 32'(parity), 1);
        chk("add_y_hi", 32'(y_hi), 0);
        tick();
        chk("drain_clr", 32'(out_valid), 0);
        chk("drain_hold_y", 32'(y), 44);

        // Chained carry: ADD 255+1 then ADC 0+0
        in_valid = 1'b1; opcode = 4'd1; A = 8'd255; B = 8'd1;
        tick();
        chk("c_add_y", 32'(c_y), 0);
        chk("c_add_car", 32'(c_car), 1);
        chk("c_add_zero", 32'(c_zero), 1);
        opcode = 4'd2; A = 8'd0; B = 8'd0;
        chk("b2b_in_ready", 32'(in_ready), 1);
        tick();
        chk("c_adc_y", 32'(c_y), 1);
        chk("c_adc_car", 32'(c_car), 0);
        chk("c_adc_valid", 32'(c_out_valid), 1);
        chk("adc_port_y", 32'(y), 0);
        car_in = 1'b1; A = 8'd3; B = 8'd4;
        tick();
        chk("adc_port_cin", 32'(y), 8);
        chk("adc_reg_cin", 32'(c_y), 7);
        in_valid = 1'b0; car_in = 1'b0;
        tick();

        // MUL 255*255
        in_valid = 1'b1; opcode = 4'd10; A = 8'd255; B = 8'd255;
        tick();
        in_valid = 1'b0;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            if (!in_ready) busy++;
            chk("mul_early_valid", 32'(out_valid), 0);
            tick();
        end
        chk("mul_valid", 32'(out_valid), 1);
        chk("mul_busy_cycles", 32'(busy), 8);
        chk("mul_y", 32'(y), 32'h01);
        chk("mul_y_hi", 32'(y_hi), 32'hFE);
        chk("mul_zero", 32'(zero), 0);
        chk("mul_parity", 32'(parity), 1);
        tick();
        chk("mul_drain", 32'(out_valid), 0);

        // Backpressure: SUB 5-10 held while a pending ADD 1+2 waits
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = 4'd3; A = 8'd5; B = 8'd10;
        tick();
        opcode = 4'd1; A = 8'd1; B = 8'd2;
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_y", 32'(y), 251);
            chk("bp_borrow", 32'(borrow), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        tick();
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_y", 32'(y), 3);
        chk("bp_next_borrow", 32'(borrow), 0);

        do_op(4'd0, 8'd5, 8'd5);
        chk("op0_inv", 32'(invalid_op), 1);
        chk("op0_y", 32'(y), 0);
        chk("op0_zero", 32'(zero), 1);
        chk("op0_car", 32'(car_out), 0);
        do_op(4'd15, 8'd7, 8'd9);
        chk("op15_inv", 32'(invalid_op), 1);
        chk("op15_y", 32'(y), 0);
        chk("op15_y_hi", 32'(y_hi), 0);
        chk("op15_zero", 32'(zero), 1);
        do_op(4'd8, 8'h99, 8'd0);
        chk("rol_y", 32'(y), 32'h33);
        chk("rol_inv", 32'(invalid_op), 0);
        do_op(4'd9, 8'h99, 8'd0);
        chk("ror_y", 32'(y), 32'hCC);
        do_op(4'd3, 8'd10, 8'd5);
        chk("sub_y", 32'(y), 5);
        chk("sub_borrow", 32'(borrow), 0);
        do_op(4'd5, 8'd0, 8'd0);
        chk("dec_y", 32'(y), 32'hFF);
        chk("dec_borrow", 32'(borrow), 1);
        do_op(4'd4, 8'd255, 8'd0);
        chk("inc_y", 32'(y), 0);
        chk("inc_car", 32'(car_out), 1);
        chk("inc_zero", 32'(zero), 1);
        do_op(4'd6, 8'hF0, 8'h3C);
        chk("and_y", 32'(y), 32'h30);
        do_op(4'd7, 8'h0F, 8'd0);
        chk("not_y", 32'(y), 32'hF0);
        do_op(4'd11, 8'hF0, 8'h0F);
        chk("or_y", 32'(y), 32'hFF);
        chk("or_parity", 32'(parity), 0);
        do_op(4'd12, 8'hFF, 8'h0F);
        chk("xor_y", 32'(y), 32'hF0);
        chk("xor_parity", 32'(parity), 0);
        in_valid = 1'b0;
        tick();

        // Reset during MUL
        in_valid = 1'b1; opcode = 4'd10; A = 8'd3; B = 8'd4;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(out_valid), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_rel_ready", 32'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("abort_no_beat", 32'(seen), 0);

        // 16-bit instance
        v16 = 1'b1; op16 = 4'd1; a16 = 16'hFFFF; b16 = 16'h0001;
        tick();
        v16 = 1'b0;
        chk("w16_valid", 32'(w_valid), 1);
        chk("w16_add_y", 32'(w_y), 0);
        chk("w16_add_car", 32'(w_car), 1);
        chk("w16_add_zero", 32'(w_zero), 1);
        v16 = 1'b1; op16 = 4'd10; a16 = 16'hFFFF; b16 = 16'hFFFF;
        tick();
        v16 = 1'b0;
        early = 0;
        for (int i = 0; i < 16; i++) begin
            if (w_valid) early++;
            tick();
        end
        chk("w16_mul_early", 32'(early), 0);
        chk("w16_mul_valid", 32'(w_valid), 1);
        chk("w16_mul_y", 32'(w_y), 32'h0001);
        chk("w16_mul_y_hi", 32'(w_hi), 32'hFFFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
